seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the datapath's combinational ALU.
- Keeps the existing 5-bit opcode map and adds these features:
  - a start/busy/done handshake;
  - iterative signed multiply (radix-2 Booth) and signed restoring divide;
  - variable-amount shifts and rotates;
  - divide-by-zero and illegal-opcode flags.
- Sits between the A/B operand registers and the Z register pair. The control unit issues `start` and waits for `done` before latching Zlow/Zhigh.

Parameters:
- `WIDTH`, 32, operand and result width. Must be a power of two, at least 4.
- `SHW`, clog2(WIDTH), localparam. Width of the shift-amount field taken from b.

Ports:
- `clock`  in  1  System clock. Everything is rising-edge.
- `clear`  in  1  Synchronous, active-high reset.
- `start`  in  1  Operation request. Sampled only in IDLE.
- `op`  in  5  Opcode, captured when start is accepted.
- `a`  in  WIDTH  Operand A, captured on start.
- `b`  in  WIDTH  Operand B, captured on start.
- `flag`  in  1  Branch condition for op 10011, captured on start.
- `busy`  out  1  High from the cycle after accept until done.
- `done`  out  1  One-cycle pulse when results are valid.
- `z_low`  out  WIDTH  Result low word, or quotient.
- `z_high`  out  WIDTH  Result high word, or remainder; 0 where unused.
- `div_zero`  out  1  Set with done when DIV has b==0.
- `illegal_op`  out  1  Set with done for an unmapped opcode.

Behaviour:
- Reset (`clear`=1 at a clock edge):
  - state goes to IDLE;
  - busy, done, div_zero and illegal_op go to 0;
  - z_low and z_high go to 0.
  - This works mid-operation: the operation in flight is aborted and no done is produced.
- States are IDLE, CALC, MUL, DIV.
- Accept: in IDLE with start=1, capture op, a, b and flag, then go to:
  - MUL for op 01111;
  - DIV for op 10000 with b≠0;
  - CALC otherwise.
- In IDLE, start=0 keeps the state. start is ignored whenever the state is not IDLE.
- CALC: one cycle. Registers z_low/z_high, pulses done, returns to IDLE. Latency is 2 edges from the accept edge.
  - op 00011 ADD, 01100 ADDI, 00000 LD, 00001 LDI, 00010 ST: z_low = a+b, modulo 2^WIDTH.
  - op 00100 SUB: z_low = a−b, modulo 2^WIDTH.
  - op 00101 AND, 00110 OR: bitwise.
  - op 10001 NEG: z_low = −b (two's complement).
  - op 10010 NOT: z_low = ~b.
  - Shifts and rotates use amount s = b[SHW−1:0]; s=0 passes a through.
    - op 01001 SHL: a<<s, zero fill.
    - op 00111 SHR: a>>s, zero fill.
    - op 01000 SHRA: a>>s, filled with a[WIDTH−1].
    - op 01011 ROL: rotate a left by s.
    - op 01010 ROR: rotate a right by s.
  - op 10011 BRADD: z_low = a+b if the captured flag=1, else a.
  - DIV with b==0: z_low = all ones, z_high = a, div_zero=1.
  - Any other opcode: z_low = 0, illegal_op=1.
  - z_high = 0 for every CALC op except divide-by-zero.
- MUL:
  - Signed WIDTH×WIDTH → 2·WIDTH Booth product; one step per cycle for WIDTH cycles.
  - done pulses on the cycle the last step completes. Latency is WIDTH+1 edges from accept.
  - z_high:z_low = full signed product.
- DIV:
  - Signed restoring divide on the magnitudes; WIDTH iterations, then sign correction in the same final cycle. Latency is WIDTH+1 edges.
  - Quotient truncates toward zero. Remainder takes the sign of a.
  - MIN/−1 gives quotient = MIN, remainder = 0.
- Flags:
  - div_zero and illegal_op are valid only while done=1 and are 0 otherwise.
- Output stability:
  - z_low and z_high hold their last results until the next done or reset.
  - They are not updated during iteration.
- busy:
  - 1 in CALC, MUL and DIV; 0 in IDLE.
  - done and busy are both 1 on the final cycle. busy falls on the following edge.
- Back-to-back operation: start may be asserted in the cycle after done. It is accepted because the state is IDLE again.
- No internal state survives between operations except z_low and z_high.

Test Plan:
- Reset mid-MUL: clear at cycle 5 of a MUL → no done pulse, busy=0, z_low=z_high=0 the next cycle. A new ADD 3+4 then gives z_low=7.
- CALC ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → z_low=0, z_high=0, done exactly 2 edges after accept.
  - SHRA a=0x80000010, s=4 → 0xF8000001.
  - ROR a=0x00000001, s=1 → 0x80000000.
- MUL −3×7 → z_high:z_low = 0xFFFFFFFF:FFFFFFEB, done exactly 33 edges after accept. A second start pulsed mid-operation is ignored.
- DIV:
  - −7/2 → z_low=0xFFFFFFFD (−3), z_high=0xFFFFFFFF (−1).
  - 0x80000000/−1 → z_low=0x80000000, z_high=0.
  - 5/0 → z_low=0xFFFFFFFF, z_high=5, div_zero=1, latency 2.
- Flag behaviour:
  - BRADD a=10, b=6: flag=1 → 16; flag=0 → 10.
  - op 11111 → z_low=0, illegal_op=1 for exactly one cycle.
- WIDTH=8 instance:
  - MUL 0x7F×0x7F → z_high:z_low = 0x3F:01, done 9 edges after accept.
  - ROL a=0x81, s=9 → s=1, result 0x03.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU with start/busy/done handshake. Single-cycle
//            logic/arith/shift ops, radix-2 Booth signed multiply, signed
//            restoring divide, divide-by-zero and illegal-opcode flags.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high,
  output logic             div_zero,
  output logic             illegal_op
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] c_opLd    = 5'b00000;
  localparam logic [4:0] c_opLdi   = 5'b00001;
  localparam logic [4:0] c_opSt    = 5'b00010;
  localparam logic [4:0] c_opAdd   = 5'b00011;
  localparam logic [4:0] c_opSub   = 5'b00100;
  localparam logic [4:0] c_opAnd   = 5'b00101;
  localparam logic [4:0] c_opOr    = 5'b00110;
  localparam logic [4:0] c_opShr   = 5'b00111;
  localparam logic [4:0] c_opShra  = 5'b01000;
  localparam logic [4:0] c_opShl   = 5'b01001;
  localparam logic [4:0] c_opRor   = 5'b01010;
  localparam logic [4:0] c_opRol   = 5'b01011;
  localparam logic [4:0] c_opAddi  = 5'b01100;
  localparam logic [4:0] c_opMul   = 5'b01111;
  localparam logic [4:0] c_opDiv   = 5'b10000;
  localparam logic [4:0] c_opNeg   = 5'b10001;
  localparam logic [4:0] c_opNot   = 5'b10010;
  localparam logic [4:0] c_opBradd = 5'b10011;

  localparam int             c_lastInt  = WIDTH - 1;
  localparam logic [SHW-1:0] c_lastStep = c_lastInt[SHW-1:0];
  localparam logic [SHW:0]   c_widthVal = WIDTH[SHW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MUL  = 2'd2,
    DIV  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_finish;

  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_flag;
  logic [SHW-1:0]   r_count;
  // Shared iteration datapath: Booth {A, Q, q-1} or divider {remainder, quotient}
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qm1;

  logic             r_busy;
  logic             r_done;
  logic             r_divZero;
  logic             r_illegal;
  logic [WIDTH-1:0] r_zLow;
  logic [WIDTH-1:0] r_zHigh;

  logic [WIDTH-1:0] w_calcLow;
  logic [WIDTH-1:0] w_calcHigh;
  logic             w_calcDz;
  logic             w_calcIll;
  logic [SHW-1:0]   w_shamt;
  logic [SHW:0]     w_shInv;

  logic [WIDTH:0]   w_mcand;
  logic [WIDTH:0]   w_boothSum;
  logic [WIDTH:0]   w_boothHi;
  logic [WIDTH-1:0] w_boothLo;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_divHi;
  logic [WIDTH-1:0] w_divLo;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_shamt = r_b[SHW-1:0];
  // Complementary rotate amount; equals WIDTH when s=0 so that half shifts out to zero
  assign w_shInv = c_widthVal - {1'b0, w_shamt};

  // Booth step: examine {Q0, q-1}, add/subtract multiplicand, arithmetic shift right
  assign w_mcand   = {r_b[WIDTH-1], r_b};
  assign w_boothHi = {w_boothSum[WIDTH], w_boothSum[WIDTH:1]};
  assign w_boothLo = {w_boothSum[0], r_lo[WIDTH-1:1]};

  // Restoring divide works on magnitudes; MIN maps to 2^(WIDTH-1) as unsigned
  assign w_absA     = a[WIDTH-1] ? -a : a;
  assign w_absB     = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_remShift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_trial    = w_remShift - {1'b0, w_absB};
  assign w_divHi    = w_trial[WIDTH] ? w_remShift : w_trial;
  assign w_divLo    = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quot     = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_divLo : w_divLo;
  assign w_rem      = r_a[WIDTH-1] ? -w_divHi[WIDTH-1:0] : w_divHi[WIDTH-1:0];

  assign busy       = r_busy;
  assign done       = r_done;
  assign z_low      = r_zLow;
  assign z_high     = r_zHigh;
  assign div_zero   = r_divZero;
  assign illegal_op = r_illegal;

  // State register
  always_ff @(posedge clock) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode and completion strobe
  always_comb begin
    w_nextState = r_state;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (op == c_opMul)                     w_nextState = MUL;
          else if (op == c_opDiv && b != '0)     w_nextState = DIV;
          else                                   w_nextState = CALC;
        end
      end
      CALC: begin
        w_nextState = IDLE;
        w_finish    = 1'b1;
      end
      MUL, DIV: begin
        if (r_count == c_lastStep) begin
          w_nextState = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Booth add/subtract selection
  always_comb begin
    w_boothSum = r_hi;
    case ({r_lo[0], r_qm1})
      2'b01:   w_boothSum = r_hi + w_mcand;
      2'b10:   w_boothSum = r_hi - w_mcand;
      default: w_boothSum = r_hi;
    endcase
  end

  // Single-cycle result for every op that completes in CALC
  always_comb begin
    w_calcLow  = '0;
    w_calcHigh = '0;
    w_calcDz   = 1'b0;
    w_calcIll  = 1'b0;
    case (r_op)
      c_opLd, c_opLdi, c_opSt, c_opAdd, c_opAddi: w_calcLow = r_a + r_b;
      c_opSub:   w_calcLow = r_a - r_b;
      c_opAnd:   w_calcLow = r_a & r_b;
      c_opOr:    w_calcLow = r_a | r_b;
      c_opNeg:   w_calcLow = -r_b;
      c_opNot:   w_calcLow = ~r_b;
      c_opShl:   w_calcLow = r_a << w_shamt;
      c_opShr:   w_calcLow = r_a >> w_shamt;
      c_opShra:  w_calcLow = $signed(r_a) >>> w_shamt;
      c_opRol:   w_calcLow = (r_a << w_shamt) | (r_a >> w_shInv);
      c_opRor:   w_calcLow = (r_a >> w_shamt) | (r_a << w_shInv);
      c_opBradd: w_calcLow = r_flag ? (r_a + r_b) : r_a;
      // Only a zero divisor reaches CALC with the divide opcode
      c_opDiv: begin
        w_calcLow  = '1;
        w_calcHigh = r_a;
        w_calcDz   = 1'b1;
      end
      default:   w_calcIll = 1'b1;
    endcase
  end

  // Operand capture, iteration datapath and result/flag registers
  always_ff @(posedge clock) begin
    if (clear) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_flag    <= 1'b0;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_qm1     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_illegal <= 1'b0;
      r_zLow    <= '0;
      r_zHigh   <= '0;
    end else begin
      r_done    <= w_finish;
      r_busy    <= (w_nextState != IDLE) || w_finish;
      r_divZero <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_flag  <= flag;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= (op == c_opDiv) ? w_absA : a;
            r_qm1   <= 1'b0;
          end
        end
        CALC: begin
          r_zLow    <= w_calcLow;
          r_zHigh   <= w_calcHigh;
          r_divZero <= w_calcDz;
          r_illegal <= w_calcIll;
        end
        MUL: begin
          r_hi    <= w_boothHi;
          r_lo    <= w_boothLo;
          r_qm1   <= r_lo[0];
          r_count <= r_count + SHW'(1);
          if (w_finish) begin
            r_zLow  <= w_boothLo;
            r_zHigh <= w_boothHi[WIDTH-1:0];
          end
        end
        DIV: begin
          r_hi    <= w_divHi;
          r_lo    <= w_divLo;
          r_count <= r_count + SHW'(1);
          if (w_finish) begin
            r_zLow  <= w_quot;
            r_zHigh <= w_rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
  localparam int W0 = 32;
  localparam int W1 = 8;

  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SHRA  = 5'b01000;
  localparam logic [4:0] OP_ROR   = 5'b01010;
  localparam logic [4:0] OP_ROL   = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_BRADD = 5'b10011;
  localparam logic [4:0] OP_BAD   = 5'b11111;

  typedef struct {
    logic [63:0] zl;
    logic [63:0] zh;
    bit          dz;
    bit          il;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic clrSeen = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic          start0 = 1'b0, flag0 = 1'b0;
  logic [4:0]    op0 = '0;
  logic [W0-1:0] a0 = '0, b0 = '0;
  logic          busy0, done0, dz0, il0;
  logic [W0-1:0] zl0, zh0;

  logic          start1 = 1'b0, flag1 = 1'b0;
  logic [4:0]    op1 = '0;
  logic [W1-1:0] a1 = '0, b1 = '0;
  logic          busy1, done1, dz1, il1;
  logic [W1-1:0] zl1, zh1;

  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] last0l = '0, last0h = '0, last1l = '0, last1h = '0;
  logic [4:0]  legalOps [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                 5'd9, 5'd10, 5'd11, 5'd12, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19};

  seq_alu #(.WIDTH(W0)) dut0 (
    .clock(clk), .clear(clear), .start(start0), .op(op0), .a(a0), .b(b0), .flag(flag0),
    .busy(busy0), .done(done0), .z_low(zl0), .z_high(zh0), .div_zero(dz0), .illegal_op(il0)
  );

  seq_alu #(.WIDTH(W1)) dut1 (
    .clock(clk), .clear(clear), .start(start1), .op(op1), .a(a1), .b(b1), .flag(flag1),
    .busy(busy1), .done(done1), .z_low(zl1), .z_high(zh1), .div_zero(dz1), .illegal_op(il1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    clrSeen <= clear;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] mask(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(logic [63:0] v, int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  // Reference: plain integer arithmetic on sign-extended operands
  function automatic exp_t model(int w, logic [4:0] op, logic [63:0] a, logic [63:0] b, bit f);
    exp_t   e;
    longint sa, sb, p;
    logic [63:0] m;
    int     s;
    m  = mask(w);
    sa = sext(a, w);
    sb = sext(b, w);
    s  = int'(b % 64'(w));
    e.zl = '0; e.zh = '0; e.dz = 1'b0; e.il = 1'b0; e.lat = 2; e.acc = 0;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: e.zl = a + b;
      5'd4:  e.zl = a - b;
      5'd5:  e.zl = a & b;
      5'd6:  e.zl = a | b;
      5'd17: e.zl = 64'd0 - b;
      5'd18: e.zl = ~b;
      5'd9:  e.zl = a << s;
      5'd7:  e.zl = a >> s;
      5'd8:  e.zl = sa >>> s;
      5'd11: e.zl = (a << s) | (a >> (w - s));
      5'd10: e.zl = (a >> s) | (a << (w - s));
      5'd19: e.zl = f ? a + b : a;
      5'd15: begin
        p = sa * sb;
        e.zl = p;
        e.zh = p >>> w;
        e.lat = w + 1;
      end
      5'd16: begin
        if (b == 64'd0) begin
          e.zl = m; e.zh = a; e.dz = 1'b1;
        end else begin
          e.zl = sa / sb; e.zh = sa % sb; e.lat = w + 1;
        end
      end
      default: e.il = 1'b1;
    endcase
    e.zl = e.zl & m;
    e.zh = e.zh & m;
    return e;
  endfunction

  function automatic logic [63:0] pick(int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask(w);
      2:       return 64'd1 << (w - 1);
      3:       return 64'd1;
      default: return {$urandom, $urandom} & mask(w);
    endcase
  endfunction

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (clrSeen) begin last0l = '0; last0h = '0; end
    if (done0) begin
      check("busy_with_done32", 64'(busy0), 64'd1);
      if (q0.size() == 0) check("unexpected_done32", 64'(done0), 64'd0);
      else begin
        e = q0.pop_front();
        check("z_low32", 64'(zl0), e.zl);
        check("z_high32", 64'(zh0), e.zh);
        check("div_zero32", 64'(dz0), 64'(e.dz));
        check("illegal_op32", 64'(il0), 64'(e.il));
        check("latency32", 64'(cyc - e.acc + 1), 64'(e.lat));
        last0l = 64'(zl0); last0h = 64'(zh0);
      end
    end else begin
      check("flags_idle32", 64'({dz0, il0}), 64'd0);
      check("z_low_hold32", 64'(zl0), last0l);
      check("z_high_hold32", 64'(zh0), last0h);
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (clrSeen) begin last1l = '0; last1h = '0; end
    if (done1) begin
      check("busy_with_done8", 64'(busy1), 64'd1);
      if (q1.size() == 0) check("unexpected_done8", 64'(done1), 64'd0);
      else begin
        e = q1.pop_front();
        check("z_low8", 64'(zl1), e.zl);
        check("z_high8", 64'(zh1), e.zh);
        check("div_zero8", 64'(dz1), 64'(e.dz));
        check("illegal_op8", 64'(il1), 64'(e.il));
        check("latency8", 64'(cyc - e.acc + 1), 64'(e.lat));
        last1l = 64'(zl1); last1h = 64'(zh1);
      end
    end else begin
      check("flags_idle8", 64'({dz1, il1}), 64'd0);
      check("z_low_hold8", 64'(zl1), last1l);
      check("z_high_hold8", 64'(zh1), last1h);
    end
  end

  // Issue one operation, push its expectation, wait (bounded) for done.
  // poke pulses a second start mid-operation, which must be ignored.
  task automatic runOp(int inst, logic [4:0] op, logic [63:0] a, logic [63:0] b, bit f, bit poke);
    exp_t e;
    int   w;
    bit   got;
    w = (inst == 0) ? W0 : W1;
    e = model(w, op, a & mask(w), b & mask(w), f);
    @(posedge clk); #1;
    e.acc = cyc + 1;
    if (inst == 0) begin
      start0 = 1'b1; op0 = op; a0 = a[W0-1:0]; b0 = b[W0-1:0]; flag0 = f; q0.push_back(e);
    end else begin
      start1 = 1'b1; op1 = op; a1 = a[W1-1:0]; b1 = b[W1-1:0]; flag1 = f; q1.push_back(e);
    end
    @(posedge clk); #1;
    if (inst == 0) begin
      start0 = 1'b0; op0 = 5'($urandom); a0 = $urandom; b0 = $urandom; flag0 = ~f;
    end else begin
      start1 = 1'b0; op1 = 5'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); flag1 = ~f;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (poke && i == 4) begin
        if (inst == 0) begin start0 = 1'b1; op0 = OP_ADD; end
        else begin start1 = 1'b1; op1 = OP_ADD; end
      end
      if (poke && i == 5) begin
        if (inst == 0) start0 = 1'b0;
        else start1 = 1'b0;
      end
      got = (inst == 0) ? done0 : done1;
    end
    check("done_within_bound", 64'(got), 64'd1);
  endtask

  task automatic idleCheck(int inst);
    @(posedge clk);
    @(negedge clk);
    check("busy_low_after_done", 64'((inst == 0) ? busy0 : busy1), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rop;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("reset_outputs32", {busy0, done0, dz0, il0, zl0, zh0}, '0);
    check("reset_outputs8", {busy1, done1, dz1, il1, zl1, zh1}, '0);

    // Directed cases on the 32-bit instance
    runOp(0, OP_ADD, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    check("add_wrap", {zh0, zl0}, 64'd0);
    idleCheck(0);
    runOp(0, OP_SHRA, 64'h8000_0010, 64'd4, 1'b0, 1'b0);
    check("shra", 64'(zl0), 64'hF800_0001);
    runOp(0, OP_ROR, 64'd1, 64'd1, 1'b0, 1'b0);
    check("ror", 64'(zl0), 64'h8000_0000);
    idleCheck(0);
    runOp(0, OP_MUL, 64'hFFFF_FFFD, 64'd7, 1'b0, 1'b1);
    check("mul_neg", {zh0, zl0}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(0, OP_DIV, 64'hFFFF_FFF9, 64'd2, 1'b0, 1'b0);
    check("div_neg", {zh0, zl0}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(0, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_min_m1", {zh0, zl0}, 64'h0000_0000_8000_0000);
    runOp(0, OP_DIV, 64'd5, 64'd0, 1'b0, 1'b0);
    check("div_by_zero", {zh0, zl0}, 64'h0000_0005_FFFF_FFFF);
    check("div_by_zero_flag", 64'(dz0), 64'd1);
    runOp(0, OP_BRADD, 64'd10, 64'd6, 1'b1, 1'b0);
    check("bradd_taken", 64'(zl0), 64'd16);
    runOp(0, OP_BRADD, 64'd10, 64'd6, 1'b0, 1'b0);
    check("bradd_not_taken", 64'(zl0), 64'd10);
    runOp(0, OP_BAD, 64'd1, 64'd2, 1'b0, 1'b0);
    check("illegal_flag", 64'({il0, zl0}), 64'h1_0000_0000);
    idleCheck(0);

    // Clear during a multiply: aborted, no done, outputs zeroed
    @(posedge clk); #1;
    start0 = 1'b1; op0 = OP_MUL; a0 = 32'd12345; b0 = 32'hFFFF_FF9D;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("clear_mid_mul", {busy0, done0, zl0, zh0}, '0);
    repeat (40) @(negedge clk);
    runOp(0, OP_ADD, 64'd3, 64'd4, 1'b0, 1'b0);
    check("add_after_clear", 64'(zl0), 64'd7);

    // Directed cases on the 8-bit instance
    runOp(1, OP_MUL, 64'h7F, 64'h7F, 1'b0, 1'b0);
    check("mul8", 64'({zh1, zl1}), 64'h3F01);
    runOp(1, OP_ROL, 64'h81, 64'd9, 1'b0, 1'b0);
    check("rol8", 64'(zl1), 64'h03);
    idleCheck(1);

    // Randomized traffic on both widths
    for (int n = 0; n < 120; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legalOps[$urandom_range(0, 17)];
      runOp(0, rop, pick(W0), pick(W0), 1'($urandom_range(0, 1)), 1'b0);
      if (n % 3 == 0) idleCheck(0);
    end
    for (int n = 0; n < 120; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legalOps[$urandom_range(0, 17)];
      runOp(1, rop, pick(W1), pick(W1), 1'($urandom_range(0, 1)), 1'b0);
      if (n % 3 == 0) idleCheck(1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained32", 64'(q0.size()), 64'd0);
    check("queue_drained8", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
